// File: rtl/router_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : router_port_arbiter
// Purpose : Packet-locked round-robin arbiter for one router output port.
//           Grants one first-word-fall-through input FIFO at a time and pops
//           a whole packet from it (src_id, dest_id, size, payload, crc)
//           before re-arbitrating. A size word above MAX_SIZE is clamped:
//           only MAX_SIZE payload words are taken and the next word is
//           treated as the crc.
// Optional: define ARB_TIMEOUT_EN to build a stall watchdog that aborts a
//           packet after TIMEOUT_CYCLES consecutive empty-FIFO stalls.
// Ports   :
//   clk, rst    clock, asynchronous active-high reset
//   req         per-FIFO "head packet is routed to this port"
//   rempty      per-FIFO empty flag
//   rdata       FIFO head words, requester i at [i*DATA_W +: DATA_W]
//   rinc        one-hot pop strobe (combinational)
//   out_full    downstream queue full
//   out_data    registered output word
//   out_valid   registered, one cycle per transferred word
//   out_last    registered, high with the crc word
//   grant       registered one-hot owner, 0 when idle
//   busy        high whenever the FSM is not IDLE
//   size_err    one-cycle pulse when a size word exceeds MAX_SIZE
//   timeout     one-cycle pulse on watchdog abort (0 without ARB_TIMEOUT_EN)
// Revision: 1.0 - initial release
// ============================================================================
module router_port_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int DATA_W         = 8,
  parameter int MAX_SIZE       = 16,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        rempty,
  input  logic [NUM_REQ*DATA_W-1:0] rdata,
  output logic [NUM_REQ-1:0]        rinc,
  input  logic                      out_full,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      size_err,
  output logic                      timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    SIZE    = 3'd2,
    PAYLOAD = 3'd3,
    CRC     = 3'd4
  } state_t;

  state_t              state, state_next;
  logic [IDX_W-1:0]    sel, sel_next;
  logic [IDX_W-1:0]    rr_last, rr_last_next;
  logic [NUM_REQ-1:0]  grant_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [DATA_W-1:0]   out_data_next;
  logic                out_valid_next, out_last_next, size_err_next, timeout_next;

  logic [DATA_W-1:0]   head;
  logic                xfer;
  logic                size_over;
  logic [CNT_W-1:0]    len;
  logic                found;
  logic [IDX_W-1:0]    pick;
  logic [IDX_W-1:0]    cand;
  logic                stall_hit;

  assign head      = rdata[int'(sel)*DATA_W +: DATA_W];
  // A word moves only when the owner has data and the port can accept it.
  assign xfer      = (state != IDLE) && !rempty[sel] && !out_full;
  assign busy      = (state != IDLE);
  assign size_over = (32'(head) > 32'(MAX_SIZE));
  assign len       = size_over ? CNT_W'(MAX_SIZE) : CNT_W'(head);

  always_comb begin
    rinc = '0;
    if (xfer) rinc[sel] = 1'b1;
  end

  // Round-robin search starting just after the last owner.
  always_comb begin
    found = 1'b0;
    pick  = rr_last;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_last) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt;

  // Only empty-FIFO stalls count; a full downstream queue is not the
  // owner's fault and must never abort a packet.
  assign stall_hit = (state != IDLE) && rempty[sel] &&
                     (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) || xfer || stall_hit) begin
      stall_cnt <= '0;
    end else if (rempty[sel]) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  always_comb begin
    state_next     = state;
    sel_next       = sel;
    rr_last_next   = rr_last;
    grant_next     = grant;
    cnt_next       = cnt;
    out_data_next  = xfer ? head : out_data;
    out_valid_next = xfer;
    out_last_next  = 1'b0;
    size_err_next  = 1'b0;
    timeout_next   = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          state_next       = HDR;
          sel_next         = pick;
          rr_last_next     = pick;
          grant_next       = '0;
          grant_next[pick] = 1'b1;
          cnt_next         = '0;
        end
      end
      HDR: begin
        // cnt counts the two header words (src_id, dest_id).
        if (xfer) begin
          if (cnt == CNT_W'(1)) begin
            state_next = SIZE;
            cnt_next   = '0;
          end else begin
            cnt_next = CNT_W'(1);
          end
        end
      end
      SIZE: begin
        if (xfer) begin
          size_err_next = size_over;
          if (len == '0) begin
            state_next = CRC;
          end else begin
            state_next = PAYLOAD;
            cnt_next   = len;
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          cnt_next = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_next = CRC;
        end
      end
      CRC: begin
        if (xfer) begin
          out_last_next = 1'b1;
          grant_next    = '0;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase

    // Watchdog abort: rr_last keeps the aborted index, no out_last.
    if (stall_hit) begin
      state_next   = IDLE;
      grant_next   = '0;
      timeout_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      rr_last   <= IDX_W'(NUM_REQ - 1);
      grant     <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      size_err  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      sel       <= sel_next;
      rr_last   <= rr_last_next;
      grant     <= grant_next;
      cnt       <= cnt_next;
      out_data  <= out_data_next;
      out_valid <= out_valid_next;
      out_last  <= out_last_next;
      size_err  <= size_err_next;
      timeout   <= timeout_next;
    end
  end

endmodule
`default_nettype wire

// File: doc/router_port_arbiter.md
Name: router_port_arbiter

Overview:
- Packet-locked round-robin arbiter for one router output port.
- Shares the output port between NUM_REQ input FIFOs. Each FIFO is first-word-fall-through: its head word is valid while its empty flag is low.
- Grants one requester, pops a whole packet from it (src_id, dest_id, size, size payload words, crc), then re-arbitrates.
- Sits between the input FIFO read side and the output port queue; drives the FIFO read-increment strobes.

Parameters:
- NUM_REQ, 3, number of requesting input FIFOs (2..8).
- DATA_W, 8, FIFO word width.
- MAX_SIZE, 16, largest legal payload length in words.
- TIMEOUT_CYCLES, 32, stall limit used by ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req  in  NUM_REQ  bit i high: FIFO i head is a packet routed to this port
- rempty  in  NUM_REQ  FIFO i empty flag
- rdata  in  NUM_REQ*DATA_W  FIFO head words, requester i at bits [i*DATA_W +: DATA_W]
- rinc  out  NUM_REQ  one-hot pop strobe to FIFO i (combinational)
- out_full  in  1  downstream port queue full
- out_data  out  DATA_W  registered output word
- out_valid  out  1  registered, high one cycle per transferred word
- out_last  out  1  registered, high with the crc word
- grant  out  NUM_REQ  registered one-hot current owner, 0 when idle
- busy  out  1  high in any state other than IDLE
- size_err  out  1  one-cycle pulse when a size word exceeds MAX_SIZE
- timeout  out  1  one-cycle pulse on watchdog abort (0 when ARB_TIMEOUT_EN is undefined)

Behaviour:
- Reset (async, any time, including mid-packet) sets:
  - state=IDLE; grant, rinc, out_valid, out_last, size_err and timeout = 0; out_data = 0.
  - rr_last = NUM_REQ-1, so requester 0 wins first.
  - No partial packet resumes after reset.
- FSM states: IDLE, HDR, SIZE, PAYLOAD, CRC.
  - IDLE: if any req bit is high, pick the first requester searching from rr_last+1 modulo NUM_REQ. Next cycle: grant is one-hot for that requester, rr_last = the chosen index, state=HDR.
  - Transfer condition xfer = selected rempty==0 && out_full==0. Only in xfer cycles do rinc[sel] and the word counter act. No xfer means hold state.
  - HDR: word 0 (src_id), then word 1 (dest_id); go to SIZE after word 1 transfers.
  - SIZE: on xfer, latch len = min(word, MAX_SIZE). If word > MAX_SIZE, pulse size_err. If len==0, go to CRC; otherwise go to PAYLOAD with cnt=len.
  - PAYLOAD: decrement cnt on each xfer; go to CRC when the word with cnt==1 transfers.
  - CRC: on xfer, out_last=1 next cycle, grant=0, state=IDLE.
- Clamping: payload words beyond MAX_SIZE are not consumed. The following word is treated as crc and the packet is ended. Recovering from the mis-framed stream is upstream's responsibility.
- Latency:
  - out_data and out_valid follow the xfer cycle by one clock.
  - One packet of size S uses S+4 xfer cycles.
  - There is at least one IDLE cycle between consecutive packets.
- req is sampled only in IDLE. req changes while locked are ignored.
- If several req bits rise in the same cycle, the round-robin order decides. Starvation-free: each waiting requester is served within NUM_REQ packets.
- rinc is never asserted for a non-granted requester and is never asserted while out_full=1. Popping an empty FIFO is impossible because xfer requires rempty==0.
- All counters are sized clog2(MAX_SIZE+1) bits; no wrap is possible.

Optional Feature:
- ARB_TIMEOUT_EN defined: a stall counter runs while busy. It clears on every xfer and increments while the granted FIFO is empty, i.e. empty-induced stalls only (out_full stalls do not count). When it reaches TIMEOUT_CYCLES:
  - timeout pulses for one cycle;
  - grant=0 and state=IDLE;
  - rr_last keeps the aborted index;
  - no out_last is produced.
- ARB_TIMEOUT_EN undefined: no counter is built, timeout is tied 0, and the arbiter waits indefinitely.

Test Plan:
- Single requester: req=3'b001; FIFO0 holds 5,10,2,0xAA,0xBB,0x37 -> grant=001, six out_valid pulses carrying the same data in order, out_last with 0x37, then grant=000 and busy=0.
- Round-robin: req=3'b111 held, each FIFO holds one size-0 packet -> grants in order 001, 010, 100. Each packet gives 4 out words, separated by exactly one IDLE cycle.
- Backpressure: out_full=1 for 3 cycles during PAYLOAD -> rinc=0 and out_valid=0 during the stall; payload intact and in order afterwards.
- Lock: req1 rises mid-packet of requester 0 -> requester 0 completes its packet, then grant=010.
- Size clamp: MAX_SIZE=16, size word=20 -> size_err pulses once; 16 payload words plus 1 crc word popped; out_last asserted.
- Reset/timeout: rst mid-PAYLOAD -> all outputs 0 immediately, then requester 0 wins first. With ARB_TIMEOUT_EN, the granted FIFO empty for 32 cycles -> timeout pulse, grant=000.
